add_pipe_n: RTL and testbench

- Parametrised, pipelined, segmented ripple adder/subtractor for the Karatsuba datapath.
- Splits WIDTH-bit operands into NSEG = WIDTH/SEG segments, adds one segment per stage, and registers the carry between stages.
- Operand skew and result deskew registers deliver full-width results at one result per cycle.
- Adds a valid/ready handshake with backpressure, an add/sub mode, and a signed-overflow flag, so it can close timing at any width the multiplier's partial-product sums need.

---
 rtl/add_pkg.sv | 12 +
 rtl/add_seg.sv | 15 +
 rtl/add_pipe_n.sv | 132 +++++++++++++
 tb/tb_add_pipe_n.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared sizing constants and helpers for the segmented adder and the Karatsuba top.
// Pure package: no logic, no state.
package add_pkg;

    localparam int ADD_WIDTH_DEF = 64;
    localparam int ADD_SEG_DEF   = 16;

    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/add_seg.sv
// One SEG-bit ripple segment of the pipelined adder.
// Latency: combinational. Backpressure: none (pure datapath).
module add_seg #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/add_pipe_n.sv
// Pipelined segmented adder/subtractor: one SEG-bit segment resolved per stage, carry registered between stages.
// Latency: NSEG cycles (beat accepted at edge k is valid after edge k+NSEG-1); one beat per cycle.
// Backpressure: single global enable, in_ready = !out_valid || out_ready; every stage holds while stalled.
module add_pipe_n
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEF,
    parameter int SEG   = ADD_SEG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = nseg(WIDTH, SEG);

    if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
        $error("add_pipe_n: WIDTH must be a positive multiple of SEG");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    // acc_q carries finished sum segments below the current stage and untouched A segments above it;
    // the remaining B' segments ride in a separate register that shrinks by one segment per stage.
    for (genvar i = 0; i < NSEG; i++) begin : g_stage
        logic [WIDTH-1:0] src_acc;
        logic [SEG-1:0]   src_b;
        logic             src_c;
        logic             src_am;
        logic             src_bm;
        logic             src_v;
        logic [SEG-1:0]   seg_sum;
        logic             seg_c;
        logic [WIDTH-1:0] nxt_acc;
        logic [WIDTH-1:0] acc_q;
        logic             cry_q;
        logic             am_q;
        logic             bm_q;
        logic             vld_q;

        if (i == 0) begin : g_head
            assign src_acc = a;
            assign src_b   = b_eff[SEG-1:0];
            assign src_c   = c0;
            assign src_am  = a[WIDTH-1];
            assign src_bm  = b_eff[WIDTH-1];
            assign src_v   = in_valid;
        end else begin : g_body
            assign src_acc = g_stage[i-1].acc_q;
            assign src_b   = g_stage[i-1].g_rem.b_rem_q[SEG-1:0];
            assign src_c   = g_stage[i-1].cry_q;
            assign src_am  = g_stage[i-1].am_q;
            assign src_bm  = g_stage[i-1].bm_q;
            assign src_v   = g_stage[i-1].vld_q;
        end

        add_seg #(
            .SEG(SEG)
        ) u_seg (
            .a   (src_acc[i*SEG +: SEG]),
            .b   (src_b),
            .cin (src_c),
            .sum (seg_sum),
            .cout(seg_c)
        );

        always_comb begin
            nxt_acc                = src_acc;
            nxt_acc[i*SEG +: SEG]  = seg_sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                acc_q <= '0;
                cry_q <= 1'b0;
                am_q  <= 1'b0;
                bm_q  <= 1'b0;
            end else if (en) begin
                vld_q <= src_v;
                acc_q <= nxt_acc;
                cry_q <= seg_c;
                am_q  <= src_am;
                bm_q  <= src_bm;
            end
        end

        if (i < NSEG - 1) begin : g_rem
            logic [WIDTH-(i+1)*SEG-1:0] b_rem_d;
            logic [WIDTH-(i+1)*SEG-1:0] b_rem_q;

            if (i == 0) begin : g_rem_head
                assign b_rem_d = b_eff[WIDTH-1:SEG];
            end else begin : g_rem_body
                assign b_rem_d = g_stage[i-1].g_rem.b_rem_q[WIDTH-i*SEG-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    b_rem_q <= '0;
                end else if (en) begin
                    b_rem_q <= b_rem_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].vld_q;
    assign sum       = g_stage[NSEG-1].acc_q;
    assign cout      = g_stage[NSEG-1].cry_q;
    // Derived only from last-stage registers, so it is as stable as sum under backpressure.
    assign ovf       = (g_stage[NSEG-1].am_q == g_stage[NSEG-1].bm_q) &&
                       (g_stage[NSEG-1].acc_q[WIDTH-1] != g_stage[NSEG-1].am_q);

endmodule

// File: tb/tb_add_pipe_n.sv
// Bench for add_pipe_n: directed cases on 64/16, then random streams on 64/16, 32/32 and 48/8 side by side.
module tb_add_pipe_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  iv, ordy, cn, sb;
    logic [2:0]  ir, ov, co, of;
    logic [63:0] a_s [3];
    logic [63:0] b_s [3];
    logic [63:0] sm0;
    logic [31:0] sm1;
    logic [47:0] sm2;

    int n_cmp = 0;
    int n_bad = 0;
    int wdt [3] = '{64, 32, 48};

    logic [65:0] q0 [$];
    logic [65:0] q1 [$];
    logic [65:0] q2 [$];

    add_pipe_n #(.WIDTH(64), .SEG(16)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0]), .b(b_s[0]), .cin(cn[0]), .sub(sb[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm0), .cout(co[0]), .ovf(of[0])
    );

    add_pipe_n #(.WIDTH(32), .SEG(32)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1][31:0]), .b(b_s[1][31:0]), .cin(cn[1]), .sub(sb[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm1), .cout(co[1]), .ovf(of[1])
    );

    add_pipe_n #(.WIDTH(48), .SEG(8)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s[2][47:0]), .b(b_s[2][47:0]), .cin(cn[2]), .sub(sb[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm2), .cout(co[2]), .ovf(of[2])
    );

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get_sum(input int d);
        case (d)
            0:       return sm0;
            1:       return {32'd0, sm1};
            default: return {16'd0, sm2};
        endcase
    endfunction

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] m;
        m = '1;
        return m >> (64 - w);
    endfunction

    function automatic logic [63:0] rnd_op(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = '0;
            2:       v = wmask(w) >> 1;
            3:       v = 64'd1 << (w - 1);
            default: v = {$urandom, $urandom};
        endcase
        return v & wmask(w);
    endfunction

    // True-value arithmetic: unsigned result for sum/cout, mathematically exact signed result for overflow.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [67:0]        ua, ub, ut, modv;
        logic signed [67:0] sa, sb_v, tr, half;
        logic               c, o;
        modv = 68'd1 << w;
        ua   = {4'd0, a};
        ub   = {4'd0, b};
        sa   = a[w-1] ? $signed(ua - modv) : $signed(ua);
        sb_v = b[w-1] ? $signed(ub - modv) : $signed(ub);
        half = $signed(modv >> 1);
        if (sub) begin
            ut = ua - ub;
            tr = sa - sb_v;
            c  = (ua >= ub);
        end else begin
            ut = ua + ub + {67'd0, cin};
            tr = sa + sb_v;
            if (cin) tr = tr + 68'sd1;
            c  = (ut >= modv);
        end
        o  = (tr >= half) || (tr < -half);
        ut = ut & (modv - 68'd1);
        return {o, c, ut[63:0]};
    endfunction

    task automatic q_push(input int d, input logic [65:0] v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_pop(input int d, output logic [65:0] v);
        case (d)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic send64(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub,
                          input logic [63:0] es, input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        iv[0] = 1'b1; a_s[0] = a; b_s[0] = b; cn[0] = cin; sb[0] = sub; ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; a_s[0] = {$urandom, $urandom}; b_s[0] = {$urandom, $urandom};
        lat = 1;
        while (!ov[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 66'(lat), 66'd4);
        chk({tag, "_sum"}, 66'(sm0), 66'(es));
        chk({tag, "_cout"}, 66'(co[0]), 66'(ec));
        chk({tag, "_ovf"}, 66'(of[0]), 66'(eo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int          idx_in, n_out, hold;
        bit          seen, prev_stall;
        logic [63:0] prev_sum;
        logic [65:0] e;
        bit          pst [3];
        logic [63:0] ps  [3];

        rst = 1'b1;
        iv = '0; ordy = '1; cn = '0; sb = '0;
        for (int d = 0; d < 3; d++) begin
            a_s[d] = '0; b_s[d] = '0; pst[d] = 1'b0; ps[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_out_valid_d%0d", d), 66'(ov[d]), 66'd0);
            chk($sformatf("reset_sum_d%0d", d), 66'(get_sum(d)), 66'd0);
            chk($sformatf("reset_cout_d%0d", d), 66'(co[d]), 66'd0);
            chk($sformatf("reset_ovf_d%0d", d), 66'(of[d]), 66'd0);
            chk($sformatf("reset_in_ready_d%0d", d), 66'(ir[d]), 66'd1);
        end

        send64("carry_seg0", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        send64("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        send64("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        send64("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        send64("sub_noborrow", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
        send64("sub_min_ovf", 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Streaming with a 3-cycle stall starting at the first result.
        idx_in = 0; n_out = 0; hold = 0; seen = 1'b0; prev_stall = 1'b0; prev_sum = '0;
        for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
            @(posedge clk); #1;
            if (ov[0] && !seen) begin
                seen = 1'b1;
                hold = 3;
            end
            ordy[0] = (hold == 0);
            if (hold > 0) hold--;
            iv[0] = (idx_in < 8);
            a_s[0] = 64'(idx_in); b_s[0] = 64'(idx_in); cn[0] = 1'b0; sb[0] = 1'b0;
            @(negedge clk);
            if (!ordy[0]) chk("bp_in_ready", 66'(ir[0]), 66'd0);
            if (prev_stall) chk("bp_hold_sum", 66'(sm0), 66'(prev_sum));
            if (ov[0] && ordy[0]) begin
                chk("stream_sum", 66'(sm0), 66'(2 * n_out));
                n_out++;
            end
            if (iv[0] && ir[0]) idx_in++;
            prev_stall = ov[0] && !ordy[0];
            prev_sum   = sm0;
        end
        chk("stream_count", 66'(n_out), 66'd8);
        @(posedge clk); #1;
        iv[0] = 1'b0; ordy[0] = 1'b1;
        chk("stream_no_dup", 66'(ov[0]), 66'd0);

        // Reset while three beats are in flight.
        for (int k = 0; k < 3; k++) begin
            iv[0] = 1'b1; a_s[0] = 64'(k + 100); b_s[0] = 64'd1; cn[0] = 1'b0; sb[0] = 1'b0;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_in_ready", 66'(ir[0]), 66'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_flush_out_valid", 66'(ov[0]), 66'd0);
        end
        send64("after_rst", 64'd40, 64'd2, 1'b1, 1'b0, 64'd43, 1'b0, 1'b0);

        // Random streams on all three configurations at once.
        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                iv[d]   = ($urandom_range(0, 3) != 0);
                ordy[d] = ($urandom_range(0, 3) != 0);
                a_s[d]  = rnd_op(wdt[d]);
                b_s[d]  = rnd_op(wdt[d]);
                cn[d]   = $urandom_range(0, 1) != 0;
                sb[d]   = $urandom_range(0, 1) != 0;
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("in_ready_rule_d%0d", d), 66'(ir[d]), 66'(!ov[d] || ordy[d]));
                if (pst[d]) chk($sformatf("stall_hold_d%0d", d), 66'(get_sum(d)), 66'(ps[d]));
                if (ov[d] && ordy[d]) begin
                    chk($sformatf("beat_expected_d%0d", d), 66'(q_size(d) > 0), 66'd1);
                    if (q_size(d) > 0) begin
                        q_pop(d, e);
                        chk($sformatf("rand_sum_d%0d", d), 66'(get_sum(d)), 66'(e[63:0]));
                        chk($sformatf("rand_cout_d%0d", d), 66'(co[d]), 66'(e[64]));
                        chk($sformatf("rand_ovf_d%0d", d), 66'(of[d]), 66'(e[65]));
                    end
                end
                if (iv[d] && ir[d]) q_push(d, model(wdt[d], a_s[d], b_s[d], cn[d], sb[d]));
                pst[d] = ov[d] && !ordy[d];
                ps[d]  = get_sum(d);
            end
        end

        // Drain whatever is still in flight.
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            iv = '0; ordy = '1;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ov[d]) begin
                    chk($sformatf("drain_expected_d%0d", d), 66'(q_size(d) > 0), 66'd1);
                    if (q_size(d) > 0) begin
                        q_pop(d, e);
                        chk($sformatf("drain_sum_d%0d", d), 66'(get_sum(d)), 66'(e[63:0]));
                        chk($sformatf("drain_cout_d%0d", d), 66'(co[d]), 66'(e[64]));
                        chk($sformatf("drain_ovf_d%0d", d), 66'(of[d]), 66'(e[65]));
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("lost_beats_d%0d", d), 66'(q_size(d)), 66'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
